// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that serialises four requesters
// onto one shared WIDTH-bit register (IDLE -> GRANT -> ACK sequence).
// Optional feature macro: SHARED_REG_LOCK_EN adds a Lock input. While the
// current owner holds Lock and Req, the block goes from ACK straight back to
// GRANT, so that owner keeps the register for back-to-back writes.
module shared_reg_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic [3:0]         Req,
   input  logic [4*WIDTH-1:0] Data,
`ifdef SHARED_REG_LOCK_EN
   input  logic               Lock,
`endif
   output logic [3:0]         Gnt,
   output logic [3:0]         Ack,
   output logic [1:0]         Owner,
   output logic               Busy,
   output logic [WIDTH-1:0]   Q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [1:0]       last_q, last_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [3:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] reg_q, reg_d;

   logic [1:0]       winner;
   logic [1:0]       idx;
   logic [WIDTH-1:0] owner_data;
   logic             hold_lock;

   // Round-robin pick: the first requester after last_q wins. The loop runs
   // downward so the nearest candidate is the last one assigned.
   always_comb begin
      winner = last_q;
      idx    = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last_q + 2'(k);
         if (Req[idx]) winner = idx;
      end
   end

   // Select the write word of the current owner.
   always_comb begin
      owner_data = '0;
      for (int j = 0; j < 4; j++) begin
         if (owner_q == 2'(j)) owner_data = Data[j*WIDTH +: WIDTH];
      end
   end

`ifdef SHARED_REG_LOCK_EN
   assign hold_lock = Lock & Req[owner_q];
`else
   assign hold_lock = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      reg_d   = reg_q;
      case (state_q)
         IDLE: begin
            ack_d = 4'b0000;
            if (Req != 4'b0000) begin
               owner_d = winner;
               gnt_d   = 4'b0001 << winner;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (Req[owner_q]) begin
               reg_d   = owner_data;
               ack_d   = 4'b0001 << owner_q;
               last_d  = owner_q;
               state_d = ACK;
            end else begin
               // Requester withdrew: no write and Last stays, so the same
               // priority order applies to the next arbitration.
               gnt_d   = 4'b0000;
               state_d = IDLE;
            end
         end
         ACK: begin
            ack_d = 4'b0000;
            if (hold_lock) begin
               state_d = GRANT;
            end else begin
               gnt_d   = 4'b0000;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = 4'b0000;
            ack_d   = 4'b0000;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; Last resets to 3 so requester 0 leads.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd3;
         gnt_q   <= 4'b0000;
         ack_q   <= 4'b0000;
         busy_q  <= 1'b0;
         reg_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         reg_q   <= reg_d;
      end
   end

   assign Gnt   = gnt_q;
   assign Ack   = ack_q;
   assign Owner = owner_q;
   assign Busy  = busy_q;
   assign Q     = reg_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Testbench for shared_reg_arbiter: expected write completions are queued
// when a request is driven and retired by a negedge monitor.
module tb_shared_reg_arbiter;

   localparam int unsigned WIDTH = 8;

   logic               clk;
   logic               rst_n;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] data;
   logic               lock;
   logic [3:0]         gnt;
   logic [3:0]         ack;
   logic [1:0]         owner;
   logic               busy;
   logic [WIDTH-1:0]   q;

   typedef struct {
      logic [3:0]       ack;
      logic [WIDTH-1:0] q;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   shared_reg_arbiter #(.WIDTH(WIDTH)) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .Req    (req),
      .Data   (data),
`ifdef SHARED_REG_LOCK_EN
      .Lock   (lock),
`endif
      .Gnt    (gnt),
      .Ack    (ack),
      .Owner  (owner),
      .Busy   (busy),
      .Q      (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expect a completion 'off' edges after the current one.
   task automatic push(input logic [3:0] a, input logic [WIDTH-1:0] d, input int off);
      exp_t e;
      e.ack = a;
      e.q   = d;
      e.cyc = cyc + off;
      sb.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      data[i*WIDTH +: WIDTH] = v;
   endtask

   // Retire the head expectation on its due cycle; any other Ack is unexpected.
   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         chk("ack_onehot", 32'(ack), 32'(sb[0].ack));
         chk("q_written",  32'(q),   32'(sb[0].q));
         void'(sb.pop_front());
      end else if (ack !== 4'b0000) begin
         chk("unexpected_ack", 32'(ack), 32'h0);
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      lock  = 1'b0;
      data  = '0;
      for (int i = 0; i < 4; i++) set_data(i, WIDTH'(8'h10 + i));
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("rst_gnt",   32'(gnt),   32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_q",     32'(q),     32'h0);
      chk("rst_owner", 32'(owner), 32'h0);

      // Round-robin with all four held: order 0,1,2,3,0, one write per 3 cycles.
      req = 4'b1111;
      for (int n = 0; n < 5; n++) push(4'b0001 << (n % 4), WIDTH'(8'h10 + (n % 4)), 2 + 3*n);
      tick(1);
      chk("rr_first_owner", 32'(owner), 32'h0);
      chk("rr_first_busy",  32'(busy),  32'h1);
      tick(14);
      req = 4'b0000;
      tick(2);

      // Single write from requester 2.
      set_data(2, 8'hA5);
      req = 4'b0100;
      push(4'b0100, 8'hA5, 2);
      tick(1);
      chk("single_gnt_k",   32'(gnt), 32'h4);
      tick(1);
      chk("single_gnt_k1",  32'(gnt), 32'h4);
      chk("single_q_k1",    32'(q),   32'hA5);
      tick(1);
      req = 4'b0000;
      chk("single_gnt_k2",  32'(gnt),  32'h0);
      chk("single_busy_k2", 32'(busy), 32'h0);
      tick(1);

      // Serve requester 3, then 1001 must wrap to 0 before 3.
      set_data(3, 8'h3C);
      req = 4'b1000;
      push(4'b1000, 8'h3C, 2);
      tick(3);
      req = 4'b1001;
      push(4'b0001, 8'h10, 2);
      push(4'b1000, 8'h3C, 5);
      tick(1);
      chk("wrap_owner0", 32'(owner), 32'h0);
      tick(3);
      chk("wrap_owner3", 32'(owner), 32'h3);
      tick(2);
      req = 4'b0000;
      tick(1);

      // Abort: requester 1 drops Req during GRANT.
      req = 4'b0010;
      tick(1);
      chk("abort_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      tick(1);
      chk("abort_gnt_low", 32'(gnt),  32'h0);
      chk("abort_busy",    32'(busy), 32'h0);
      chk("abort_q_hold",  32'(q),    32'h3C);
      req = 4'b0011;
      push(4'b0001, 8'h10, 2);
      tick(1);
      chk("abort_next_owner", 32'(owner), 32'h0);
      tick(2);
      req = 4'b0000;
      tick(1);

      // Reset asserted mid-cycle while a write is in GRANT.
      req = 4'b0100;
      tick(1);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_q",    32'(q),    32'h0);
      chk("async_rst_gnt",  32'(gnt),  32'h0);
      chk("async_rst_ack",  32'(ack),  32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      req = 4'b0000;
      tick(1);
      #2 rst_n = 1'b1;
      tick(1);
      // Last is back to 3: from 1010, requester 1 is next.
      req = 4'b1010;
      push(4'b0010, 8'h11, 2);
      tick(1);
      chk("post_rst_owner", 32'(owner), 32'h1);
      tick(2);
      req = 4'b0000;
      tick(1);

`ifdef SHARED_REG_LOCK_EN
      // Locked back-to-back writes by requester 0 while requester 1 waits.
      set_data(0, 8'h01);
      req  = 4'b0011;
      lock = 1'b1;
      push(4'b0001, 8'h01, 2);
      push(4'b0001, 8'h02, 4);
      push(4'b0001, 8'h03, 6);
      push(4'b0010, 8'h11, 9);
      tick(2);
      set_data(0, 8'h02);
      tick(1);
      chk("lock_gnt_held", 32'(gnt),  32'h1);
      chk("lock_busy",     32'(busy), 32'h1);
      tick(1);
      set_data(0, 8'h03);
      tick(2);
      lock = 1'b0;
      tick(2);
      chk("unlock_owner", 32'(owner), 32'h1);
      tick(1);
      req = 4'b0000;
      tick(2);
`endif

      tick(3);
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit storage register built from clock-enabled D flip-flops.
- Four requesters compete for write access. The block grants one requester at a time, loads that requester's data into the register, and acknowledges completion.
- The register lives inside this block. Q is the readback.

Parameters:
WIDTH, 8, width of the shared register and of each requester data word

Ports:
Clock   input   1          rising-edge clock
Resetn  input   1          asynchronous, active-low reset
Req     input   4          Req[i] high = requester i wants to write
Data    input   4*WIDTH    Data[i*WIDTH +: WIDTH] = write word of requester i
Gnt     output  4          one-hot grant, registered
Ack     output  4          one-hot, one-cycle write-complete pulse, registered
Owner   output  2          index of current/last granted requester
Busy    output  1          high whenever state is not IDLE
Q       output  WIDTH      shared register contents

Behaviour:
- Clocking and reset: one clock (Clock). Reset is asynchronous, active-low (Resetn).
- Reset values: state=IDLE, Q=0, Gnt=0, Ack=0, Owner=0, Busy=0. Internal Last=3, so requester 0 has first priority.
- States: IDLE, GRANT, ACK.
- IDLE:
  - If Req==0, stay.
  - Otherwise pick the winner: first i with Req[i]=1, searching (Last+1) mod 4 upward with wrap.
  - Owner<=winner, Gnt<=onehot(winner), go GRANT.
- GRANT (exactly one cycle):
  - If Req[Owner]=1 at the edge: Q<=Data[Owner], Ack<=onehot(Owner), Last<=Owner, go ACK.
  - If Req[Owner]=0 (abort): no write, no Ack, Last unchanged, Gnt<=0, go IDLE.
- ACK (exactly one cycle): Gnt<=0, Ack<=0, go IDLE.
- Busy=1 in GRANT and ACK.
- Latency: Req sampled at edge k.
  - Gnt high after k.
  - Q updated and Ack high after k+1.
  - Gnt/Ack low and IDLE after k+2.
  - Next arbitration at edge k+3.
- Throughput: one write per 3 cycles.
- Data sampling: Data[Owner] is sampled only at the GRANT->ACK edge. Requesters hold Data stable while Gnt is high.
- Requests on other lines during GRANT/ACK are ignored until IDLE. They are not queued; Req level is re-sampled.
- Fairness: with all four Req held high, the grant order is 0,1,2,3,0,...
- A single persistent requester is re-granted every 3 cycles.
- Reset mid-operation: immediate return to reset values. An in-flight write is lost (Q=0).
- Q holds its value in all cycles except the GRANT->ACK edge.

Optional Feature:
Macro: SHARED_REG_LOCK_EN
- Defined:
  - Adds input port Lock (1 bit, listed after Data).
  - In ACK, if Lock=1 and Req[Owner]=1: go directly to GRANT for the same Owner. Gnt stays high, no re-arbitration, Last unchanged until the next write.
  - Locked back-to-back writes take 2 cycles each.
  - Lock is ignored in IDLE and GRANT.
- Not defined: no Lock port; ACK always returns to IDLE.

Test Plan:
- Reset: Resetn=0 asynchronously mid-cycle -> Q=0x00, Gnt=0, Ack=0, Busy=0 immediately, without waiting for Clock.
- Single write: Req=4'b0100, Data[2]=0xA5 held -> Gnt=4'b0100 after 1 edge; Q=0xA5 and Ack=4'b0100 after 2 edges; Gnt=0, Busy=0 after 3 edges.
- Round-robin: Req=4'b1111 held, Data[i]=0x10+i -> Ack sequence 0,1,2,3,0 at 3-cycle spacing; Q follows 0x10,0x11,0x12,0x13,0x10.
- Wrap-around: after requester 3 is served, Req=4'b1001 -> requester 0 granted next. Then, with Req=4'b1001 still held, requester 3 is granted.
- Abort: Req=4'b0010, drop Req[1] during GRANT -> no Ack, Q unchanged, Busy=0 next cycle. A following Req=4'b0011 grants requester 0 first (Last unchanged at 3).
- SHARED_REG_LOCK_EN: Req=4'b0011, Lock=1 with Owner=0 -> requester 0 writes 0x01,0x02,0x03 at 2-cycle spacing with requester 1 starved. Lock=0 -> requester 1 granted next.
